// File: rtl/l1_i_cache_sa.sv
// l1_i_cache_sa: parametrised set-associative L1 instruction cache.
// Per-set round-robin replacement, walking flush (one set per cycle),
// read/ready line fill from L2. Optional counters via L1_I_PERF_CNT_EN.
module l1_i_cache_sa #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 512,
    parameter int unsigned WORD_W = 32,
    parameter int unsigned SETS   = 64,
    parameter int unsigned WAYS   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              read_C_L1,
    input  logic              flush,
    output logic              stall,
    output logic [WORD_W-1:0] read_data_L1_C,
    output logic              valid_L1_C,
    output logic              read_L1_L2,
    output logic [ADDR_W-1:0] addr_L1_L2,
    input  logic              ready_L2_L1,
    input  logic [LINE_W-1:0] read_data_L2_L1,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
);

    localparam int unsigned OFF_W  = $clog2(LINE_W / 8);
    localparam int unsigned IDX_W  = $clog2(SETS);
    localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int unsigned NWORDS = LINE_W / WORD_W;
    localparam int unsigned WSEL_W = $clog2(NWORDS);
    localparam int unsigned LOW_W  = OFF_W - WSEL_W;
    localparam int unsigned PTR_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, MISS, FLUSH} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   fsh_idx_q, fsh_idx_d;
    logic [ADDR_W-1:0]  miss_addr;

    logic [WAYS-1:0]    valid_q [SETS];
    logic [PTR_W-1:0]   ptr_q   [SETS];
    logic [TAG_W-1:0]   tag_q   [SETS][WAYS];
    logic [LINE_W-1:0]  data_q  [SETS][WAYS];

    logic [IDX_W-1:0]   idx, m_idx;
    logic [TAG_W-1:0]   tag, m_tag;
    logic [WSEL_W-1:0]  wsel, m_wsel;
    logic               hit_any, hit, inv_any;
    logic [PTR_W-1:0]   hit_way, inv_way, victim;
    logic [WORD_W-1:0]  hit_word, fill_word;
    logic               do_hit, do_miss, do_fill;
    logic               unused_low;

    assign idx    = addr[OFF_W +: IDX_W];
    assign tag    = addr[OFF_W+IDX_W +: TAG_W];
    assign wsel   = addr[LOW_W +: WSEL_W];
    assign m_idx  = miss_addr[OFF_W +: IDX_W];
    assign m_tag  = miss_addr[OFF_W+IDX_W +: TAG_W];
    assign m_wsel = miss_addr[LOW_W +: WSEL_W];
    assign unused_low = ^{addr[LOW_W-1:0], miss_addr[LOW_W-1:0]};

    // Tag compare across the ways of the addressed set; lowest matching way wins
    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
                hit_any = 1'b1;
                hit_way = PTR_W'(w);
            end
        end
    end

    assign hit = read_C_L1 & hit_any;

    // Word selection from the hit line and from the incoming fill line
    always_comb begin
        hit_word  = '0;
        fill_word = '0;
        for (int i = 0; i < NWORDS; i++) begin
            if (wsel == WSEL_W'(i))
                hit_word = data_q[idx][hit_way][i*WORD_W +: WORD_W];
            if (m_wsel == WSEL_W'(i))
                fill_word = read_data_L2_L1[i*WORD_W +: WORD_W];
        end
    end

    // Victim: lowest invalid way, otherwise the set's round-robin pointer
    always_comb begin
        inv_any = 1'b0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[m_idx][w]) begin
                inv_any = 1'b1;
                inv_way = PTR_W'(w);
            end
        end
        victim = inv_any ? inv_way : ptr_q[m_idx];
    end

    assign do_hit  = (state_q == IDLE) && !flush && hit;
    assign do_miss = (state_q == IDLE) && !flush && read_C_L1 && !hit_any;
    assign do_fill = (state_q == MISS) && ready_L2_L1;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            fsh_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            fsh_idx_q <= fsh_idx_d;
        end
    end

    // Next-state and stall decode
    always_comb begin
        state_d   = state_q;
        fsh_idx_d = fsh_idx_q;
        stall     = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush) begin
                    state_d   = FLUSH;
                    fsh_idx_d = '0;
                    stall     = 1'b1;
                end else if (read_C_L1 && !hit_any) begin
                    state_d = MISS;
                    stall   = 1'b1;
                end
            end
            MISS: begin
                stall = 1'b1;
                if (ready_L2_L1)
                    state_d = IDLE;
            end
            FLUSH: begin
                stall     = 1'b1;
                fsh_idx_d = fsh_idx_q + 1'b1;
                if (fsh_idx_q == IDX_W'(SETS - 1))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered core/L2 outputs and the latched miss address
    always_ff @(posedge clk) begin
        if (rst) begin
            read_data_L1_C <= '0;
            valid_L1_C     <= 1'b0;
            read_L1_L2     <= 1'b0;
            addr_L1_L2     <= '0;
            miss_addr      <= '0;
        end else begin
            valid_L1_C <= do_hit | do_fill;
            if (do_hit)
                read_data_L1_C <= hit_word;
            else if (do_fill)
                read_data_L1_C <= fill_word;
            if (do_miss) begin
                read_L1_L2 <= 1'b1;
                addr_L1_L2 <= {addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                miss_addr  <= addr;
            end else if (do_fill) begin
                read_L1_L2 <= 1'b0;
            end
        end
    end

    // Valid bits and replacement pointers: fill sets, flush walks and clears
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                ptr_q[s]   <= '0;
            end
        end else if (do_fill) begin
            valid_q[m_idx][victim] <= 1'b1;
            if (!inv_any)
                ptr_q[m_idx] <= (WAYS > 1) ? ptr_q[m_idx] + 1'b1 : '0;
        end else if (state_q == FLUSH) begin
            valid_q[fsh_idx_q] <= '0;
            ptr_q[fsh_idx_q]   <= '0;
        end
    end

    // Tag and data arrays; contents only matter where valid is set
    always_ff @(posedge clk) begin
        if (do_fill) begin
            tag_q[m_idx][victim]  <= m_tag;
            data_q[m_idx][victim] <= read_data_L2_L1;
        end
    end

`ifdef L1_I_PERF_CNT_EN
    logic [31:0] hit_q, miss_q;

    // Hit/miss event counters, wrap naturally, survive flush
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            if (do_hit)
                hit_q <= hit_q + 32'd1;
            if (do_miss)
                miss_q <= miss_q + 32'd1;
        end
    end

    assign hit_cnt  = hit_q;
    assign miss_cnt = miss_q;
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_l1_i_cache_sa.sv
// Directed bench for l1_i_cache_sa at default parameters (64 sets, 2 ways, 512-bit lines).
module tb_l1_i_cache_sa;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  addr = '0;
    logic         read_C_L1 = 1'b0;
    logic         flush = 1'b0;
    logic         stall;
    logic [31:0]  read_data_L1_C;
    logic         valid_L1_C;
    logic         read_L1_L2;
    logic [31:0]  addr_L1_L2;
    logic         ready_L2_L1 = 1'b0;
    logic [511:0] read_data_L2_L1 = '0;
    logic [31:0]  hit_cnt;
    logic [31:0]  miss_cnt;

    int checks = 0;
    int failures = 0;
    int exp_hits = 0;
    int exp_misses = 0;
    int cnt;
    logic [31:0] lines [10];

    l1_i_cache_sa dut (
        .clk             (clk),
        .rst             (rst),
        .addr            (addr),
        .read_C_L1       (read_C_L1),
        .flush           (flush),
        .stall           (stall),
        .read_data_L1_C  (read_data_L1_C),
        .valid_L1_C      (valid_L1_C),
        .read_L1_L2      (read_L1_L2),
        .addr_L1_L2      (addr_L1_L2),
        .ready_L2_L1     (ready_L2_L1),
        .read_data_L2_L1 (read_data_L2_L1),
        .hit_cnt         (hit_cnt),
        .miss_cnt        (miss_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] la, input int i);
        if (la == 32'h0000_1040 && i == 1)
            return 32'hDEAD_BEEF;
        return la ^ (32'(i) << 28);
    endfunction

    function automatic logic [511:0] make_line(input logic [31:0] la);
        logic [511:0] l;
        for (int i = 0; i < 16; i++)
            l[i*32 +: 32] = word_of(la, i);
        return l;
    endfunction

    task automatic chk(input string t, input logic [63:0] o, input logic [63:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", t, o, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_counters(input string t);
`ifdef L1_I_PERF_CNT_EN
        chk({t, " hit_cnt"}, 64'(hit_cnt), 64'(exp_hits));
        chk({t, " miss_cnt"}, 64'(miss_cnt), 64'(exp_misses));
`else
        chk({t, " hit_cnt"}, 64'(hit_cnt), 64'd0);
        chk({t, " miss_cnt"}, 64'(miss_cnt), 64'd0);
`endif
    endtask

    // One fetch; on a miss L2 answers after one extra waiting cycle
    task automatic fetch(input logic [31:0] a, input bit exp_hit, input string t);
        logic [31:0] la;
        logic [31:0] w;
        la = {a[31:6], 6'b0};
        w  = word_of(la, int'(a[5:2]));
        addr = a;
        read_C_L1 = 1'b1;
        #1;
        chk({t, " stall"}, 64'(stall), 64'(!exp_hit));
        if (exp_hit) begin
            tick();
            exp_hits++;
            chk({t, " hit valid"}, 64'(valid_L1_C), 64'd1);
            chk({t, " hit data"}, 64'(read_data_L1_C), 64'(w));
            chk({t, " hit no l2 req"}, 64'(read_L1_L2), 64'd0);
        end else begin
            tick();
            exp_misses++;
            chk({t, " l2 req"}, 64'(read_L1_L2), 64'd1);
            chk({t, " l2 addr"}, 64'(addr_L1_L2), 64'(la));
            chk({t, " no early valid"}, 64'(valid_L1_C), 64'd0);
            addr = 32'hFFFF_FFFC;
            tick();
            read_data_L2_L1 = make_line(la);
            ready_L2_L1 = 1'b1;
            tick();
            ready_L2_L1 = 1'b0;
            chk({t, " fill valid"}, 64'(valid_L1_C), 64'd1);
            chk({t, " fill data"}, 64'(read_data_L1_C), 64'(w));
            chk({t, " req dropped"}, 64'(read_L1_L2), 64'd0);
            addr = a;
            #1;
            chk({t, " stall after fill"}, 64'(stall), 64'd0);
        end
        read_C_L1 = 1'b0;
        tick();
        chk({t, " valid pulse ends"}, 64'(valid_L1_C), 64'd0);
    endtask

    // Counts cycles the cache keeps stall high, bounded
    task automatic count_stall(output int n);
        n = 0;
        while (stall && n < 200) begin
            tick();
            n++;
        end
    endtask

    initial begin
        lines[0] = 32'h0000_1044;
        lines[1] = 32'h0001_0140;
        lines[2] = 32'h0002_0140;
        for (int k = 0; k < 7; k++)
            lines[3+k] = 32'h0000_2000 + 32'(k) * 32'h40;

        // Reset
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst stall", 64'(stall), 64'd0);
        chk("rst read_L1_L2", 64'(read_L1_L2), 64'd0);
        chk("rst addr_L1_L2", 64'(addr_L1_L2), 64'd0);
        chk("rst valid", 64'(valid_L1_C), 64'd0);
        chk("rst data", 64'(read_data_L1_C), 64'd0);
        chk_counters("rst");

        // Cold miss then hit in the same line
        fetch(32'h0000_1044, 1'b0, "cold");
        fetch(32'h0000_1048, 1'b1, "hit");
        chk_counters("after hit");

        // Conflict in set 5: A,B fill; C evicts A; A evicts B
        fetch(32'h0001_0140, 1'b0, "A1");
        fetch(32'h0002_0140, 1'b0, "B1");
        fetch(32'h0003_0148, 1'b0, "C1");
        fetch(32'h0001_014C, 1'b0, "A2");
        fetch(32'h0003_0150, 1'b1, "C hit");
        fetch(32'h0002_0144, 1'b0, "B2");
        fetch(32'h0001_0154, 1'b1, "A hit");

        // Fill the rest of the ten lines, then flush
        for (int k = 3; k < 10; k++)
            fetch(lines[k], 1'b0, "fill10");
        fetch(32'h0000_1040, 1'b1, "pre-flush hit");
        flush = 1'b1;
        #1;
        chk("flush stall idle", 64'(stall), 64'd1);
        tick();
        flush = 1'b0;
        count_stall(cnt);
        chk("flush cycles", 64'(cnt), 64'd64);
        for (int k = 0; k < 10; k++)
            fetch(lines[k], 1'b0, "post-flush");

        // Flush raised mid-miss waits for the fill
        addr = 32'h0000_3004;
        read_C_L1 = 1'b1;
        tick();
        exp_misses++;
        flush = 1'b1;
        tick();
        chk("midmiss req held", 64'(read_L1_L2), 64'd1);
        chk("midmiss stall", 64'(stall), 64'd1);
        read_data_L2_L1 = make_line(32'h0000_3000);
        ready_L2_L1 = 1'b1;
        tick();
        ready_L2_L1 = 1'b0;
        chk("midmiss fill valid", 64'(valid_L1_C), 64'd1);
        chk("midmiss fill data", 64'(read_data_L1_C), 64'(word_of(32'h0000_3000, 1)));
        chk("midmiss flush pending", 64'(stall), 64'd1);
        read_C_L1 = 1'b0;
        tick();
        flush = 1'b0;
        chk("deferred flush no valid", 64'(valid_L1_C), 64'd0);
        count_stall(cnt);
        chk("deferred flush cycles", 64'(cnt), 64'd64);
        fetch(32'h0000_3004, 1'b0, "after deferred flush");
        chk_counters("pre-reset");

        // Reset while waiting on L2
        addr = 32'h0000_3008;
        read_C_L1 = 1'b1;
        #1;
        chk("pre-rst hit stall", 64'(stall), 64'd0);
        addr = 32'h0000_4008;
        tick();
        chk("rst-miss req", 64'(read_L1_L2), 64'd1);
        tick();
        rst = 1'b1;
        tick();
        exp_hits = 0;
        exp_misses = 0;
        chk("rst-miss req low", 64'(read_L1_L2), 64'd0);
        chk("rst-miss valid low", 64'(valid_L1_C), 64'd0);
        chk("rst-miss stall idle miss", 64'(stall), 64'd1);
        rst = 1'b0;
        read_C_L1 = 1'b0;
        tick();
        chk_counters("after reset");
        fetch(32'h0000_4008, 1'b0, "rst refetch");
        fetch(32'h0000_3008, 1'b0, "rst cleared valid");
        fetch(32'h0000_400C, 1'b1, "rst line hit");
        chk_counters("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/l1_i_cache_sa.md
Name: l1_i_cache_sa

Overview:
Parametrised set-associative L1 instruction cache. It generalises the direct-mapped L1 I-cache to configurable address width, line width, set count and associativity, with per-set round-robin replacement and a multi-cycle walking flush. It sits between the core fetch port and L2, using the same read/ready line-fill handshake toward L2.

Parameters:
ADDR_W, 32, fetch address width; the upper bits form the tag.
LINE_W, 512, cache line width in bits; a power of 2 and ≥ 2*WORD_W.
WORD_W, 32, fetch word width returned to the core.
SETS, 64, number of sets; a power of 2 and ≥ 2.
WAYS, 2, associativity; a power of 2, from 1 to 8.
Derived: OFF_W=log2(LINE_W/8), IDX_W=log2(SETS), TAG_W=ADDR_W-IDX_W-OFF_W, WSEL_W=log2(LINE_W/WORD_W).

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous reset, active-high
addr  in  ADDR_W  fetch address; byte offset bits [log2(WORD_W/8)-1:0] are ignored
read_C_L1  in  1  core fetch request
flush  in  1  invalidate-all request; level-sensitive, sampled in IDLE only
stall  out  1  core must hold addr and read_C_L1
read_data_L1_C  out  WORD_W  fetched word
valid_L1_C  out  1  one-cycle pulse, read_data_L1_C valid
read_L1_L2  out  1  line-fill request to L2
addr_L1_L2  out  ADDR_W  line-aligned fill address, low OFF_W bits zero
ready_L2_L1  in  1  L2 line valid this cycle
read_data_L2_L1  in  LINE_W  fill line
hit_cnt  out  32  hit counter (see Optional Feature)
miss_cnt  out  32  miss counter (see Optional Feature)

Behaviour:
- Storage: per set and per way, a valid bit, a TAG_W tag and a LINE_W data register. Per set, a log2(WAYS)-bit round-robin pointer (0 width when WAYS=1).
- Reset (rst=1 at an edge): state=IDLE; all valid bits=0; all pointers=0; read_L1_L2=0; addr_L1_L2=0; read_data_L1_C=0; valid_L1_C=0; counters=0. Tag and data arrays are not cleared. Reset takes precedence over every other event, including mid-miss and mid-flush; read_L1_L2 is low the cycle after reset is sampled.
- Lookup is combinational on addr. hit = read_C_L1 & (some way has valid & tag match). If several ways match (illegal), the lowest way index wins.
- stall = (state!=IDLE) | (state==IDLE & read_C_L1 & ~hit) | (state==IDLE & flush). It is combinational.
- FSM states: IDLE, MISS, FLUSH.
- IDLE, priority order:
  - flush=1: go to FLUSH, set fsh_idx=0, ignore read_C_L1.
  - Else hit: at the edge, read_data_L1_C <= selected word at addr[OFF_W-1:OFF_W-WSEL_W]; valid_L1_C <= 1. Hit latency is 1 cycle.
  - Else read_C_L1 and miss: latch addr into miss_addr, read_L1_L2 <= 1, addr_L1_L2 <= line-aligned addr, go to MISS.
- MISS:
  - read_L1_L2 stays 1; addr input changes are ignored.
  - On the edge where ready_L2_L1=1, the victim way is chosen as: the lowest invalid way in the set, else the way at the set's pointer. The victim is written with the line, tag and valid=1. The pointer advances by 1 (mod WAYS) only when a valid way was evicted.
  - On that same edge, read_data_L1_C <= requested word taken from read_data_L2_L1; valid_L1_C <= 1; read_L1_L2 <= 0; go to IDLE.
  - Miss latency = cycles until ready + 1.
  - flush asserted during MISS is not acted on until the fill completes.
- FLUSH:
  - Each cycle, clear all valid bits of set fsh_idx and reset its pointer to 0, then increment fsh_idx.
  - After set SETS-1, go to IDLE. Flush takes exactly SETS cycles.
  - If flush is still high on return to IDLE, a new flush starts.
- ready_L2_L1 is ignored outside MISS.
- valid_L1_C is 0 on every edge that produces no hit or fill.

Optional Feature:
Macro L1_I_PERF_CNT_EN.
- Defined: hit_cnt increments on each IDLE hit edge; miss_cnt increments on each IDLE→MISS transition. Both are 32-bit, wrap at 2^32, cleared by rst, and not cleared by flush.
- Undefined: hit_cnt and miss_cnt are tied to 0 and no counter logic is synthesised.

Test Plan:
- Cold miss: after rst, fetch addr=0x0000_1044. Expect stall=1, read_L1_L2=1, addr_L1_L2=0x0000_1040. Return line with word1=0xDEADBEEF and ready for 1 cycle. Expect valid_L1_C pulse with 0xDEADBEEF; stall=0 next cycle.
- Hit: refetch 0x0000_1048. Expect no L2 request, valid_L1_C after 1 cycle with line word2; with macro on, hit_cnt=1 and miss_cnt=1.
- Conflict, WAYS=2: fill tags A, B, C to index 5. C evicts A (pointer 0→1); refetch A evicts B. Expect a miss for A, and a hit for C at that point.
- Flush: assert flush after filling 10 lines. Expect stall high for exactly 64 cycles; then all 10 addresses miss. Flush raised mid-MISS is deferred until after the fill.
- Reset mid-miss: rst during MISS with ready never given. Expect read_L1_L2=0 next cycle, IDLE, and the same address misses again.
- Parameter sweep: SETS=16, WAYS=4, LINE_W=256. Run 1000 random fetches against a reference model; expect data and hit/miss agreement for every access.
